// File: rtl/fifo_ctrl_pkg.sv
// Shared helpers for the fifo_ctrl slice; widths are still derived locally from Depth.
package fifo_ctrl_pkg;

  // Pointer width for a power-of-two depth, never narrower than one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_mem.sv
// Simple dual-port RAM: one write port, one read port with a one-cycle registered read.
// No reset on the array; a read of a slot written on the same edge returns the old word.
module fifo_mem
  import fifo_ctrl_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 4,
  parameter int Depth     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [DataWidth-1:0] i_wr_data,
  input  logic [AddrWidth-1:0] i_rd_addr,
  output logic [DataWidth-1:0] o_rd_data
);

  logic [DataWidth-1:0] mem_array [Depth];
  logic [DataWidth-1:0] rd_data_reg;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_array[i_wr_addr] <= i_wr_data;
    end
    rd_data_reg <= mem_array[i_rd_addr];
  end

  assign o_rd_data = rd_data_reg;

endmodule

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller around a registered-read RAM.
// Define FIFO_COUNT_EN to expose the occupancy as o_count.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int Depth     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [DataWidth-1:0] i_wr_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic [DataWidth-1:0] o_rd_data
`ifdef FIFO_COUNT_EN
  ,
  output logic [$clog2(Depth):0] o_count
`endif
);

  localparam int AW = addr_bits(Depth);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(Depth);
  localparam logic [AW:0]   OCC_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   occ_reg, occ_next;
  logic          rd_valid_reg, rd_valid_next;
  logic [AW-1:0] mem_rd_addr;
  logic          wr_fire, pop, advance, has_unpresented;

  // Ready depends only on registered occupancy, so a pop cannot make room for a same-cycle write.
  assign o_wr_ready      = (occ_reg != FULL_COUNT);
  assign wr_fire         = i_wr_valid && o_wr_ready;
  assign pop             = rd_valid_reg && i_rd_ready;
  assign has_unpresented = (occ_reg > {{AW{1'b0}}, rd_valid_reg});
  assign advance         = (!rd_valid_reg || i_rd_ready) && has_unpresented;

  // When not advancing, re-read the presented slot so the output word stays put.
  assign mem_rd_addr = advance ? rd_ptr_reg : (rd_ptr_reg - PTR_ONE);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    occ_next      = occ_reg;
    rd_valid_next = rd_valid_reg;

    if (wr_fire) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (advance) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    case ({wr_fire, pop})
      2'b10:   occ_next = occ_reg + OCC_ONE;
      2'b01:   occ_next = occ_reg - OCC_ONE;
      default: occ_next = occ_reg;
    endcase

    if (advance) begin
      rd_valid_next = 1'b1;
    end else if (pop) begin
      rd_valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      occ_reg      <= occ_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  assign o_rd_valid = rd_valid_reg;

`ifdef FIFO_COUNT_EN
  assign o_count = occ_reg;
`endif

  fifo_mem #(
    .DataWidth (DataWidth),
    .AddrWidth (AW),
    .Depth     (Depth)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (wr_fire),
    .i_wr_addr (wr_ptr_reg),
    .i_wr_data (i_wr_data),
    .i_rd_addr (mem_rd_addr),
    .o_rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: scoreboard of committed writes checked on every pop.
// o_count checks are active only when FIFO_COUNT_EN is defined.
module tb_fifo_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic [7:0] i_wr_data;
  logic       o_rd_valid;
  logic       i_rd_ready;
  logic [7:0] o_rd_data;
`ifdef FIFO_COUNT_EN
  logic [4:0] o_count;
`endif

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [7:0] sb [$];

  fifo_ctrl #(.DataWidth(8), .Depth(16)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .i_wr_data  (i_wr_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_rd_data  (o_rd_data)
`ifdef FIFO_COUNT_EN
    ,
    .o_count    (o_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard: pops are compared against the oldest committed write.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_rd_valid && i_rd_ready) begin
        checks++;
        pops++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %02h, expected no data", o_rd_data);
        end else begin
          logic [7:0] exp_d;
          exp_d = sb.pop_front();
          $display("pop data=%02h exp=%02h", o_rd_data, exp_d);
          if (o_rd_data !== exp_d) begin
            errors++;
            $display("FAIL pop_data: got %02h, expected %02h", o_rd_data, exp_d);
          end
        end
      end
      if (i_wr_valid && o_wr_ready) begin
        sb.push_back(i_wr_data);
        $display("push data=%02h", i_wr_data);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b1;
    while ((sb.size() != 0 || o_rd_valid) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: left=%0d valid=%b, expected 0 and 0", sb.size(), o_rd_valid);
    end
    i_rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_wr_valid = 1'b0; i_rd_ready = 1'b0; i_wr_data = '0;
    tick(); tick();
    checks++;
    if (o_rd_valid !== 1'b0 || o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: valid=%b ready=%b, expected 0 1", o_rd_valid, o_wr_ready);
    end
`ifdef FIFO_COUNT_EN
    checks++;
    if (o_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, expected 0", o_count);
    end
`endif
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    i_wr_valid = 1'b1; i_wr_data = 8'hA5; i_rd_ready = 1'b1;
    tick();
    i_wr_valid = 1'b0;
    checks++;
    if (o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c1_valid: got %b, expected 0", o_rd_valid);
    end
`ifdef FIFO_COUNT_EN
    checks++;
    if (o_count !== 5'd1) begin
      errors++;
      $display("FAIL single_count1: got %0d, expected 1", o_count);
    end
`endif
    tick();
    checks++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_c2: valid=%b data=%02h, expected 1 a5", o_rd_valid, o_rd_data);
    end
    tick();
    checks++;
    if (o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c3_valid: got %b, expected 0", o_rd_valid);
    end
`ifdef FIFO_COUNT_EN
    checks++;
    if (o_count !== 5'd0) begin
      errors++;
      $display("FAIL single_count0: got %0d, expected 0", o_count);
    end
`endif
    i_rd_ready = 1'b0;
  endtask

  task automatic test_fill();
    int p0;
    i_rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i_wr_valid = 1'b1; i_wr_data = 8'(i);
      @(negedge i_clk);
      checks++;
      if (o_wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready_%0d: got %b, expected 1", i, o_wr_ready);
      end
      tick();
    end
    i_wr_data = 8'h10;
    @(negedge i_clk);
    checks++;
    if (o_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full_ready: got %b, expected 0", o_wr_ready);
    end
`ifdef FIFO_COUNT_EN
    checks++;
    if (o_count !== 5'd16) begin
      errors++;
      $display("FAIL fill_count: got %0d, expected 16", o_count);
    end
`endif
    tick();
    p0 = pops;
    drain();
    checks++;
    if (pops - p0 != 16) begin
      errors++;
      $display("FAIL fill_pop_count: got %0d, expected 16", pops - p0);
    end
  endtask

  task automatic test_full_pop_write();
    i_rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i_wr_valid = 1'b1; i_wr_data = 8'(8'h20 + i);
      tick();
    end
    i_wr_data = 8'h55; i_rd_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_wr_ready !== 1'b0 || o_rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL fullpw_c0: ready=%b valid=%b, expected 0 1", o_wr_ready, o_rd_valid);
    end
    tick();
    @(negedge i_clk);
    checks++;
    if (o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL fullpw_c1_ready: got %b, expected 1", o_wr_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 40; i++) begin
      i_wr_valid = 1'b1; i_wr_data = 8'(i * 3 + 1); i_rd_ready = 1'b1;
      @(negedge i_clk);
      checks++;
      if (o_wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready_%0d: got %b, expected 1", i, o_wr_ready);
      end
      if (i >= 2) begin
        checks++;
        if (o_rd_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_valid_%0d: got %b, expected 1", i, o_rd_valid);
        end
`ifdef FIFO_COUNT_EN
        checks++;
        if (o_count !== 5'd2) begin
          errors++;
          $display("FAIL stream_count_%0d: got %0d, expected 2", i, o_count);
        end
`endif
      end
      tick();
    end
    drain();
  endtask

  task automatic test_stall();
    int n = 0;
    i_wr_valid = 1'b1; i_wr_data = 8'h70; i_rd_ready = 1'b0;
    tick();
    i_wr_valid = 1'b0;
    while (!o_rd_valid && n < 10) begin
      tick();
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      i_wr_valid = (c < 3); i_wr_data = 8'(8'h71 + c);
      @(negedge i_clk);
      checks++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h70) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b data=%02h, expected 1 70", c, o_rd_valid, o_rd_data);
      end
      tick();
    end
    i_wr_valid = 1'b0;
    checks++;
    if (sb.size() != 4) begin
      errors++;
      $display("FAIL stall_entries: got %0d, expected 4", sb.size());
    end
`ifdef FIFO_COUNT_EN
    checks++;
    if (o_count !== 5'd4) begin
      errors++;
      $display("FAIL stall_count: got %0d, expected 4", o_count);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    int p0;
    i_rd_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      i_wr_valid = 1'b1; i_wr_data = 8'(8'hC0 + i);
      tick();
    end
    i_wr_valid = 1'b0;
    tick();
    #2;
    i_rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (o_rd_valid !== 1'b0 || o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_flags: valid=%b ready=%b, expected 0 1", o_rd_valid, o_wr_ready);
    end
`ifdef FIFO_COUNT_EN
    checks++;
    if (o_count !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_count: got %0d, expected 0", o_count);
    end
`endif
    i_wr_valid = 1'b1; i_wr_data = 8'hEE; i_rd_ready = 1'b1;
    tick();
    i_wr_valid = 1'b0; i_rd_ready = 1'b0;
    i_rst = 1'b0;
    tick();
    checks++;
    if (o_rd_valid !== 1'b0 || o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ignored: valid=%b ready=%b, expected 0 1", o_rd_valid, o_wr_ready);
    end
    p0 = pops;
    i_wr_valid = 1'b1; i_wr_data = 8'h3C;
    tick();
    drain();
    checks++;
    if (pops - p0 != 1) begin
      errors++;
      $display("FAIL rstmid_pops: got %0d, expected 1", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop_write();
    test_stream();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
